// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, timing states,
// instruction classes and the datapath strobe bundle.
package cpu_defs_pkg;

   localparam int OPW      = 5;
   localparam int T_STATES = 7;
   localparam int TSW      = $clog2(T_STATES);

   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPW-1:0] OP_AND  = 5'b00101;
   localparam logic [OPW-1:0] OP_OR   = 5'b00110;
   localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
   localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
   localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
   localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
   localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
   localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
   localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
   localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPW-1:0] OP_HALT = 5'b11011;

   localparam logic [OPW-1:0] ALU_NONE = 5'b00000;

   typedef enum logic [3:0] {
      ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      CLS_NOP, CLS_BIN, CLS_MULDIV, CLS_UNARY, CLS_HALT
   } op_class_e;

   typedef struct packed {
      logic pc_out;
      logic inc_pc;
      logic pc_in;
      logic mar_in;
      logic read;
      logic mdr_in;
      logic mdr_out;
      logic ir_in;
      logic y_in;
      logic z_in;
      logic zlow_out;
      logic zhigh_out;
      logic hi_in;
      logic lo_in;
      logic gr_a;
      logic gr_b;
      logic gr_c;
      logic r_in;
      logic r_out;
   } strobes_t;

   // Unlisted opcodes fall into CLS_NOP so they simply refetch.
   function automatic op_class_e op_class(input logic [OPW-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHRA, OP_SHL, OP_ROR, OP_ROL:    return CLS_BIN;
         OP_MUL, OP_DIV:                     return CLS_MULDIV;
         OP_NEG, OP_NOT:                     return CLS_UNARY;
         OP_HALT:                            return CLS_HALT;
         default:                            return CLS_NOP;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode from the current timing state, the opcode and
// the memory / ALU handshakes.
module ctrl_decode
   import cpu_defs_pkg::*;
(
   input  state_e         state,
   input  logic [OPW-1:0] opcode,
   input  logic           mem_rdy,
   input  logic           alu_done,
   output strobes_t       strb,
   output logic [OPW-1:0] alu_op,
   output logic           run,
   output logic [TSW-1:0] tstate
);

   op_class_e cls;

   always_comb begin
      strb   = '0;
      alu_op = ALU_NONE;
      run    = 1'b1;
      tstate = '0;
      cls    = op_class(opcode);
      unique case (state)
         ST_T0: begin
            tstate      = TSW'(0);
            strb.pc_out = 1'b1;
            strb.mar_in = 1'b1;
            strb.inc_pc = 1'b1;
            strb.z_in   = 1'b1;
         end
         ST_T1: begin
            // PC loads only on the ready cycle so a long wait increments it once.
            tstate        = TSW'(1);
            strb.zlow_out = 1'b1;
            strb.read     = 1'b1;
            strb.mdr_in   = 1'b1;
            strb.pc_in    = mem_rdy;
         end
         ST_T2: begin
            tstate       = TSW'(2);
            strb.mdr_out = 1'b1;
            strb.ir_in   = 1'b1;
         end
         ST_T3: begin
            tstate = TSW'(3);
            case (cls)
               CLS_BIN, CLS_MULDIV: begin
                  strb.gr_b  = 1'b1;
                  strb.r_out = 1'b1;
                  strb.y_in  = 1'b1;
               end
               CLS_UNARY: begin
                  strb.gr_b  = 1'b1;
                  strb.r_out = 1'b1;
                  strb.z_in  = 1'b1;
                  alu_op     = opcode;
               end
               default: ;
            endcase
         end
         ST_T4: begin
            tstate = TSW'(4);
            case (cls)
               CLS_BIN: begin
                  strb.gr_c  = 1'b1;
                  strb.r_out = 1'b1;
                  strb.z_in  = 1'b1;
                  alu_op     = opcode;
               end
               CLS_MULDIV: begin
                  strb.gr_c  = 1'b1;
                  strb.r_out = 1'b1;
                  strb.z_in  = alu_done;
                  alu_op     = opcode;
               end
               CLS_UNARY: begin
                  strb.zlow_out = 1'b1;
                  strb.gr_a     = 1'b1;
                  strb.r_in     = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            tstate = TSW'(5);
            case (cls)
               CLS_BIN: begin
                  strb.zlow_out = 1'b1;
                  strb.gr_a     = 1'b1;
                  strb.r_in     = 1'b1;
               end
               CLS_MULDIV: begin
                  strb.zlow_out = 1'b1;
                  strb.lo_in    = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T6: begin
            tstate = TSW'(6);
            if (cls == CLS_MULDIV) begin
               strb.zhigh_out = 1'b1;
               strb.hi_in     = 1'b1;
            end
         end
         default: run = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: timing-state register and next-state logic; all
// strobes are decoded combinationally by ctrl_decode.
module control_sequencer
   import cpu_defs_pkg::*;
(
   input  logic           clk,
   input  logic           clr,
   input  logic [31:0]    ir,
   input  logic           mem_rdy,
   input  logic           alu_done,
   output logic           PCout,
   output logic           incPC,
   output logic           PCin,
   output logic           MARin,
   output logic           Read,
   output logic           MDRin,
   output logic           MDRout,
   output logic           IRin,
   output logic           Yin,
   output logic           Zin,
   output logic           Zlowout,
   output logic           Zhighout,
   output logic           HIin,
   output logic           LOin,
   output logic           Gra,
   output logic           Grb,
   output logic           Grc,
   output logic           Rin,
   output logic           Rout,
   output logic [OPW-1:0] alu_op,
   output logic           run,
   output logic [TSW-1:0] tstate
);

   state_e         state_q, state_d;
   op_class_e      cls;
   logic [OPW-1:0] opcode;
   strobes_t       strb;
   logic           ir_unused;

   // At T2 the datapath bypasses MDR onto ir, so the branch reads the new opcode.
   assign opcode    = ir[31 -: OPW];
   assign ir_unused = ^ir[31-OPW:0];

   always_comb begin
      state_d = state_q;
      cls     = op_class(opcode);
      unique case (state_q)
         ST_RST: state_d = ST_T0;
         ST_T0:  state_d = ST_T1;
         ST_T1:  if (mem_rdy) state_d = ST_T2;
         ST_T2: begin
            case (cls)
               CLS_BIN, CLS_MULDIV, CLS_UNARY: state_d = ST_T3;
               CLS_HALT:                       state_d = ST_HALT;
               default:                        state_d = ST_T0;
            endcase
         end
         ST_T3: state_d = (cls == CLS_NOP || cls == CLS_HALT) ? ST_T0 : ST_T4;
         ST_T4: begin
            case (cls)
               CLS_BIN:    state_d = ST_T5;
               CLS_MULDIV: if (alu_done) state_d = ST_T5;
               default:    state_d = ST_T0;
            endcase
         end
         ST_T5:   state_d = (cls == CLS_MULDIV) ? ST_T6 : ST_T0;
         ST_T6:   state_d = ST_T0;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) state_q <= ST_RST;
      else     state_q <= state_d;
   end

   ctrl_decode u_decode (
      .state    (state_q),
      .opcode   (opcode),
      .mem_rdy  (mem_rdy),
      .alu_done (alu_done),
      .strb     (strb),
      .alu_op   (alu_op),
      .run      (run),
      .tstate   (tstate)
   );

   assign PCout    = strb.pc_out;
   assign incPC    = strb.inc_pc;
   assign PCin     = strb.pc_in;
   assign MARin    = strb.mar_in;
   assign Read     = strb.read;
   assign MDRin    = strb.mdr_in;
   assign MDRout   = strb.mdr_out;
   assign IRin     = strb.ir_in;
   assign Yin      = strb.y_in;
   assign Zin      = strb.z_in;
   assign Zlowout  = strb.zlow_out;
   assign Zhighout = strb.zhigh_out;
   assign HIin     = strb.hi_in;
   assign LOin     = strb.lo_in;
   assign Gra      = strb.gr_a;
   assign Grb      = strb.gr_b;
   assign Grc      = strb.gr_c;
   assign Rin      = strb.r_in;
   assign Rout     = strb.r_out;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: per-instruction expected strobe traces are queued by the
// stimulus process and compared cycle by cycle by a separate monitor.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [31:0] ir = '0;
   logic        mem_rdy = 1'b0;
   logic        alu_done = 1'b0;
   logic PCout, incPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin, Zin;
   logic Zlowout, Zhighout, HIin, LOin, Gra, Grb, Grc, Rin, Rout, run;
   logic [4:0] alu_op;
   logic [2:0] tstate;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk(clk), .clr(clr), .ir(ir), .mem_rdy(mem_rdy), .alu_done(alu_done),
      .PCout(PCout), .incPC(incPC), .PCin(PCin), .MARin(MARin), .Read(Read),
      .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
      .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .alu_op(alu_op), .run(run), .tstate(tstate)
   );

   localparam logic [18:0] M_PCOUT  = 19'h1 << 18, M_INCPC = 19'h1 << 17,
                           M_PCIN   = 19'h1 << 16, M_MARIN = 19'h1 << 15,
                           M_READ   = 19'h1 << 14, M_MDRIN = 19'h1 << 13,
                           M_MDROUT = 19'h1 << 12, M_IRIN  = 19'h1 << 11,
                           M_YIN    = 19'h1 << 10, M_ZIN   = 19'h1 << 9,
                           M_ZLOW   = 19'h1 << 8,  M_ZHIGH = 19'h1 << 7,
                           M_HIIN   = 19'h1 << 6,  M_LOIN  = 19'h1 << 5,
                           M_GRA    = 19'h1 << 4,  M_GRB   = 19'h1 << 3,
                           M_GRC    = 19'h1 << 2,  M_RIN   = 19'h1 << 1,
                           M_ROUT   = 19'h1;

   typedef struct packed {
      logic [18:0] strb;
      logic [4:0]  alu;
      logic        run;
      logic [2:0]  ts;
      logic        ts_chk;
   } exp_t;

   exp_t  exp_q[$];
   string lbl_q[$];
   int    n_cmp = 0;
   int    n_err = 0;

   function automatic logic rb();
      logic [31:0] r;
      r = $urandom;
      return r[0];
   endfunction

   // Instruction kinds as listed in the opcode table: 1 two-operand ALU,
   // 2 mul/div, 3 one-operand, 4 halt, 0 everything else.
   function automatic int kind(input logic [4:0] op);
      int v;
      v = int'(op);
      if (v >= 3 && v <= 11) return 1;
      if (v == 15 || v == 16) return 2;
      if (v == 17 || v == 18) return 3;
      if (v == 27) return 4;
      return 0;
   endfunction

   // One clock cycle: apply inputs, queue the outputs expected for this cycle.
   task automatic cyc(input logic [31:0] ir_v, input logic rdy, input logic done,
                      input logic clr_v, input logic [18:0] s, input logic [4:0] a,
                      input logic r, input int ts, input logic chk, input string lbl);
      exp_t e;
      ir = ir_v; mem_rdy = rdy; alu_done = done; clr = clr_v;
      e.strb = s; e.alu = a; e.run = r; e.ts = 3'(ts); e.ts_chk = chk;
      exp_q.push_back(e);
      lbl_q.push_back(lbl);
      @(posedge clk);
      #1;
   endtask

   task automatic rst_cycle(input logic clr_v);
      cyc($urandom, rb(), rb(), clr_v, '0, 5'b0, 1'b0, 0, 1'b1, "RST");
   endtask

   // abort_at >= 0 asserts clr on that cycle of a mul/div result wait.
   task automatic exec(input logic [31:0] instr, input int wait_n, input int done_n,
                       input int abort_at, input int halt_n);
      logic [4:0] op;
      int k;
      op = instr[31:27];
      k  = kind(op);
      cyc($urandom, rb(), rb(), 1'b0, M_PCOUT|M_MARIN|M_INCPC|M_ZIN, 5'b0, 1'b1, 0, 1'b1, "T0");
      for (int w = 0; w < wait_n; w++)
         cyc($urandom, 1'b0, rb(), 1'b0, M_ZLOW|M_READ|M_MDRIN, 5'b0, 1'b1, 1, 1'b1, "T1wait");
      cyc($urandom, 1'b1, rb(), 1'b0, M_ZLOW|M_READ|M_MDRIN|M_PCIN, 5'b0, 1'b1, 1, 1'b1, "T1");
      cyc(instr, rb(), rb(), 1'b0, M_MDROUT|M_IRIN, 5'b0, 1'b1, 2, 1'b1, "T2");
      case (k)
         1: begin
            cyc(instr, rb(), rb(), 1'b0, M_GRB|M_ROUT|M_YIN, 5'b0, 1'b1, 3, 1'b1, "bin T3");
            cyc(instr, rb(), rb(), 1'b0, M_GRC|M_ROUT|M_ZIN, op, 1'b1, 4, 1'b1, "bin T4");
            cyc(instr, rb(), rb(), 1'b0, M_ZLOW|M_GRA|M_RIN, 5'b0, 1'b1, 5, 1'b1, "bin T5");
         end
         2: begin
            cyc(instr, rb(), rb(), 1'b0, M_GRB|M_ROUT|M_YIN, 5'b0, 1'b1, 3, 1'b1, "md T3");
            for (int d = 0; d <= done_n; d++) begin
               if (d == abort_at) begin
                  cyc(instr, rb(), 1'b0, 1'b1, M_GRC|M_ROUT, op, 1'b1, 4, 1'b1, "md T4 clr");
                  rst_cycle(1'b0);
                  return;
               end
               if (d < done_n)
                  cyc(instr, rb(), 1'b0, 1'b0, M_GRC|M_ROUT, op, 1'b1, 4, 1'b1, "md T4 wait");
               else
                  cyc(instr, rb(), 1'b1, 1'b0, M_GRC|M_ROUT|M_ZIN, op, 1'b1, 4, 1'b1, "md T4");
            end
            cyc(instr, rb(), rb(), 1'b0, M_ZLOW|M_LOIN, 5'b0, 1'b1, 5, 1'b1, "md T5");
            cyc(instr, rb(), rb(), 1'b0, M_ZHIGH|M_HIIN, 5'b0, 1'b1, 6, 1'b1, "md T6");
         end
         3: begin
            cyc(instr, rb(), rb(), 1'b0, M_GRB|M_ROUT|M_ZIN, op, 1'b1, 3, 1'b1, "un T3");
            cyc(instr, rb(), rb(), 1'b0, M_ZLOW|M_GRA|M_RIN, 5'b0, 1'b1, 4, 1'b1, "un T4");
         end
         4: begin
            // The debug index is left unchecked while halted.
            for (int h = 0; h < halt_n; h++)
               cyc($urandom, rb(), rb(), 1'b0, '0, 5'b0, 1'b0, 0, 1'b0, "HALT");
            cyc($urandom, rb(), rb(), 1'b1, '0, 5'b0, 1'b0, 0, 1'b0, "HALT clr");
            rst_cycle(1'b0);
         end
         default: ;
      endcase
   endtask

   // Monitor: every cycle with a queued expectation is compared mid-cycle.
   always @(negedge clk) begin
      exp_t        e;
      string       l;
      logic [18:0] act;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         l   = lbl_q.pop_front();
         act = {PCout, incPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin, Zin,
                Zlowout, Zhighout, HIin, LOin, Gra, Grb, Grc, Rin, Rout};
         n_cmp++;
         if (act !== e.strb || alu_op !== e.alu || run !== e.run ||
             (e.ts_chk && tstate !== e.ts)) begin
            n_err++;
            $display("FAIL %s @%0t: got strb=%b alu_op=%b run=%b tstate=%0d, want strb=%b alu_op=%b run=%b tstate=%0d",
                     l, $time, act, alu_op, run, tstate, e.strb, e.alu, e.run, e.ts);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic [4:0]  op;
      int          dn, ab;
      @(posedge clk);
      #1;
      rst_cycle(1'b1);
      rst_cycle(1'b0);
      // Directed cases from the test plan.
      exec(32'h18988000, 0, 0, -1, 0);
      exec(32'h18988000, 3, 0, -1, 0);
      r = $urandom; exec({5'b10000, r[26:0]}, 0, 5, -1, 0);
      r = $urandom; exec({5'b10001, r[26:0]}, 1, 0, -1, 0);
      r = $urandom; exec({5'b11011, r[26:0]}, 0, 0, -1, 20);
      r = $urandom; exec({5'b01111, r[26:0]}, 0, 6, 2, 0);
      r = $urandom; exec({5'b11010, r[26:0]}, 2, 0, -1, 0);
      // Randomized instruction stream.
      for (int i = 0; i < 150; i++) begin
         r  = $urandom;
         op = r[31:27];
         dn = int'($urandom_range(0, 4));
         ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, dn)) : -1;
         exec({op, r[26:0]}, int'($urandom_range(0, 3)), dn, ab, int'($urandom_range(1, 5)));
      end
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
